// File: rtl/key_ctrl.sv
// key_ctrl: samples N active-low push-buttons, synchronises and debounces
// each one, latches press events and raises a maskable level interrupt.
// Registers (word address): 0 STATE (ro), 1 PEND (w1c), 2 MASK (rw), 3 zero.

// Per-key debouncer: 2-state FSM, accepts a level only after DEB_CYCLES
// consecutive cycles of disagreement with the current stable level.
module key_deb #(
    parameter int DEB_CYCLES = 20000,
    parameter int CNT_W      = $clog2(DEB_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic pressed_s,
    output logic stable,
    output logic rise
);
    localparam logic IDLE    = 1'b0;
    localparam logic CONFIRM = 1'b1;

    logic             state;
    logic [CNT_W-1:0] cnt;
    logic             differ;
    logic             done;

    assign differ = pressed_s ^ stable;
    // cnt reaches DEB_CYCLES-1 only after at least one CONFIRM cycle
    assign done   = differ && (state == CONFIRM) && (cnt == CNT_W'(DEB_CYCLES - 1));
    // press event fires on the same edge that stable goes 0->1
    assign rise   = done & pressed_s;

    // any agreeing cycle restarts the count, so a glitch never accumulates
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            stable <= 1'b0;
        end else if (!differ) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (done) begin
            state  <= IDLE;
            cnt    <= '0;
            stable <= pressed_s;
        end else begin
            state <= CONFIRM;
            cnt   <= cnt + 1'b1;
        end
    end
endmodule

module key_ctrl #(
    parameter int N_KEYS     = 8,
    parameter int DEB_CYCLES = 20000,
    parameter int CNT_W      = $clog2(DEB_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] KIn,
    input  logic [1:0]        Addr,
    input  logic              WE,
    input  logic [31:0]       DIn,
    output logic [31:0]       DOut,
    output logic              IRQ
);
    logic [N_KEYS-1:0] sync1, sync2;
    logic [N_KEYS-1:0] pressed_s;
    logic [N_KEYS-1:0] stable;
    logic [N_KEYS-1:0] set_now;
    logic [N_KEYS-1:0] pend, mask;
    logic [N_KEYS-1:0] rdata;
    logic              wr_pend, wr_mask;
    logic              irq_q;

    // 2-flop synchroniser; resets to "released" so a held key is seen as a new press
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= KIn;
            sync2 <= sync1;
        end
    end

    assign pressed_s = ~sync2;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_deb #(
            .DEB_CYCLES(DEB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_deb (
            .clk      (clk),
            .reset    (reset),
            .pressed_s(pressed_s[i]),
            .stable   (stable[i]),
            .rise     (set_now[i])
        );
    end

    assign wr_pend = WE && (Addr == 2'd1);
    assign wr_mask = WE && (Addr == 2'd2);

    // pending events: write-1-to-clear, a same-cycle set wins over the clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       pend <= '0;
        else if (wr_pend) pend <= (pend & ~DIn[N_KEYS-1:0]) | set_now;
        else              pend <= pend | set_now;
    end

    // interrupt mask
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       mask <= '0;
        else if (wr_mask) mask <= DIn[N_KEYS-1:0];
    end

    // registered IRQ keeps KIn and the bus off any combinational path to CP0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) irq_q <= 1'b0;
        else        irq_q <= |(pend & mask);
    end

    assign IRQ = irq_q;

    // read mux
    always_comb begin
        rdata = '0;
        case (Addr)
            2'd0:    rdata = stable;
            2'd1:    rdata = pend;
            2'd2:    rdata = mask;
            default: rdata = '0;
        endcase
    end

    assign DOut = 32'(rdata);

    if (N_KEYS < 32) begin : g_pad
        logic unused_din;
        assign unused_din = ^DIn[31:N_KEYS];
    end
endmodule

// File: tb/tb_key_ctrl.sv
// Directed bench for key_ctrl with N_KEYS=8, DEB_CYCLES=4.
module tb_key_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  KIn;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] DIn;
    logic [31:0] DOut;
    logic        IRQ;

    int ntests = 0;
    int nfail  = 0;

    key_ctrl #(.N_KEYS(8), .DEB_CYCLES(4)) dut (
        .clk  (clk),
        .reset(reset),
        .KIn  (KIn),
        .Addr (Addr),
        .WE   (WE),
        .DIn  (DIn),
        .DOut (DOut),
        .IRQ  (IRQ)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        Addr = a;
        #1;
        check(tag, DOut, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = a;
        DIn  = d;
        WE   = 1'b1;
        tick(1);
        WE   = 1'b0;
        DIn  = '0;
    endtask

    initial begin
        reset = 1'b0; KIn = 8'h00; Addr = 2'd0; WE = 1'b0; DIn = '0;
        tick(2);

        // reset state with all keys held
        rd("rst_state", 2'd0, 32'h0);
        rd("rst_pend",  2'd1, 32'h0);
        rd("rst_mask",  2'd2, 32'h0);
        rd("rst_a3",    2'd3, 32'h0);
        check("rst_irq", {31'b0, IRQ}, 32'h0);

        // release reset with keys held: press seen after exactly 6 edges
        reset = 1'b1;
        tick(5);
        rd("hold_state_e5", 2'd0, 32'h0);
        tick(1);
        rd("hold_state_e6", 2'd0, 32'hFF);
        rd("hold_pend_e6",  2'd1, 32'hFF);
        KIn = 8'hFF;
        tick(6);
        rd("hold_rel_state", 2'd0, 32'h0);
        wr(2'd1, 32'hFF);
        rd("hold_pend_clr", 2'd1, 32'h0);

        // clean press / release of key 3
        KIn = 8'hF7;
        tick(5);
        rd("press3_state_e5", 2'd0, 32'h0);
        rd("press3_pend_e5",  2'd1, 32'h0);
        tick(1);
        rd("press3_state_e6", 2'd0, 32'h08);
        rd("press3_pend_e6",  2'd1, 32'h08);
        KIn = 8'hFF;
        tick(5);
        rd("rel3_state_e5", 2'd0, 32'h08);
        tick(1);
        rd("rel3_state_e6", 2'd0, 32'h0);
        rd("rel3_pend",     2'd1, 32'h08);
        wr(2'd1, 32'h08);
        rd("rel3_pend_clr", 2'd1, 32'h0);

        // bounce on key 0: low 3, high 1, low 3, high
        KIn = 8'hFE; tick(3);
        KIn = 8'hFF; tick(1);
        KIn = 8'hFE; tick(3);
        KIn = 8'hFF; tick(8);
        rd("bounce_state", 2'd0, 32'h0);
        rd("bounce_pend",  2'd1, 32'h0);
        KIn = 8'hFE; tick(8);
        rd("bounce_hold_pend",  2'd1, 32'h01);
        rd("bounce_hold_state", 2'd0, 32'h01);
        KIn = 8'hFF; tick(8);
        wr(2'd1, 32'hFF);

        // interrupt on masked key 3
        wr(2'd2, 32'h08);
        KIn = 8'hF7;
        tick(6);
        rd("irq_pend3", 2'd1, 32'h08);
        check("irq_lag", {31'b0, IRQ}, 32'h0);
        tick(1);
        check("irq_rise", {31'b0, IRQ}, 32'h1);
        KIn = 8'hFF;
        tick(6);
        check("irq_level", {31'b0, IRQ}, 32'h1);
        wr(2'd1, 32'h08);
        rd("irq_pend_clr", 2'd1, 32'h0);
        tick(1);
        check("irq_fall", {31'b0, IRQ}, 32'h0);

        // key 5 pending while masked, then unmask, then mask again
        wr(2'd2, 32'h0);
        KIn = 8'hDF;
        tick(6);
        rd("irq5_pend", 2'd1, 32'h20);
        tick(1);
        check("irq5_masked", {31'b0, IRQ}, 32'h0);
        wr(2'd2, 32'h20);
        check("irq5_unmask_lag", {31'b0, IRQ}, 32'h0);
        tick(1);
        check("irq5_unmask", {31'b0, IRQ}, 32'h1);
        wr(2'd2, 32'h0);
        tick(1);
        check("irq5_remask", {31'b0, IRQ}, 32'h0);
        rd("irq5_pend_kept", 2'd1, 32'h20);
        KIn = 8'hFF;
        tick(6);
        wr(2'd1, 32'hFF);

        // clear of PEND[2] lands on the edge key 2 becomes stable
        KIn = 8'hFB;
        tick(5);
        rd("coll_pend_pre", 2'd1, 32'h0);
        wr(2'd1, 32'h04);
        rd("coll_pend", 2'd1, 32'h04);
        rd("coll_state", 2'd0, 32'h04);
        KIn = 8'hFF;
        tick(6);
        wr(2'd1, 32'hFF);

        // bus map
        wr(2'd0, 32'hFFFFFFFF);
        wr(2'd3, 32'hFFFFFFFF);
        rd("bus_state", 2'd0, 32'h0);
        rd("bus_a3",    2'd3, 32'h0);
        rd("bus_pend",  2'd1, 32'h0);
        rd("bus_mask0", 2'd2, 32'h0);
        wr(2'd2, 32'hFFFFFFFF);
        rd("bus_mask",  2'd2, 32'h000000FF);
        wr(2'd2, 32'h0);

        // reset mid-count, key 1 kept down through reset
        KIn = 8'hFD;
        tick(3);
        wr(2'd2, 32'hFF);
        reset = 1'b0;
        #1;
        rd("mid_rst_mask", 2'd2, 32'h0);
        rd("mid_rst_state", 2'd0, 32'h0);
        check("mid_rst_irq", {31'b0, IRQ}, 32'h0);
        tick(2);
        reset = 1'b1;
        tick(5);
        rd("mid_rel_pend_e5", 2'd1, 32'h0);
        tick(1);
        rd("mid_rel_pend_e6", 2'd1, 32'h02);
        KIn = 8'hFF;
        tick(6);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
